// File: rtl/gpio_arb_pkg.sv
// rtl/gpio_arb_pkg.sv - shared types and constants for the GPIO Wishbone arbiter
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [7:0] DEFAULT_TIMEOUT = 8'd255;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

endpackage

// File: rtl/gpio_arb_watchdog.sv
// rtl/gpio_arb_watchdog.sv - unacknowledged-strobe counter, fires once per TIMEOUT stalled cycles
module gpio_arb_watchdog
  import gpio_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic fire_o
);

  logic [7:0] cnt_q, cnt_d;

  assign fire_o = (cnt_q == TIMEOUT);

  // Firing restarts the count so a still-hung slave is terminated again later.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || ack_i || fire_o) begin
      cnt_d = 8'd0;
    end else if (stb_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_wb_arbiter.sv
// rtl/gpio_wb_arbiter.sv - two-master round-robin Wishbone arbiter in front of the GPIO slave
// Optional watchdog termination enabled by GPIO_ARB_WATCHDOG_EN.
module gpio_wb_arbiter
  import gpio_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       gnt0, gnt1;
  logic       wd_fire;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = (last_q == MASTER1) ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = MASTER0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = MASTER1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= MASTER1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef GPIO_ARB_WATCHDOG_EN
  logic wd_hit;

  gpio_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_d != state_q),
    .stb_i  ((gnt0 & m0_stb_i) | (gnt1 & m1_stb_i)),
    .ack_i  (s_ack_i),
    .fire_o (wd_hit)
  );

  assign wd_fire = wd_hit & (gnt0 | gnt1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_fire        = 1'b0;
`endif

  // Master cyc/stb gate the return path so a late slave ack never reaches a released master.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = 32'd0;
    s_sel_o  = 4'd0;
    s_dat_o  = 32'd0;
    m0_dat_o = 32'd0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = 32'd0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (gnt0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i & ~wd_fire;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_sel_o  = m0_sel_i;
      s_dat_o  = m0_dat_i;
      m0_dat_o = s_dat_i;
      m0_ack_o = m0_cyc_i & m0_stb_i & s_ack_i;
      m0_err_o = wd_fire;
    end else if (gnt1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i & ~wd_fire;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_sel_o  = m1_sel_i;
      s_dat_o  = m1_dat_i;
      m1_dat_o = s_dat_i;
      m1_ack_o = m1_cyc_i & m1_stb_i & s_ack_i;
      m1_err_o = wd_fire;
    end
  end

endmodule
